// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline hazard/forwarding controller.
//   SEL_RF      - forwarding select value meaning "take operand from the register file"
//   PC_IDX_DEF  - default register index that is never forwarded (PC)
//   RB_MAX      - storage width of a slot's destination index (RB must not exceed it)
//   slot_t      - per-stage shadow record {v, rd, we, ld}
//   sel_width() - width of a forwarding select for a given tracking depth
package pipe_pkg;

    localparam int unsigned SEL_RF     = 0;
    localparam int unsigned PC_IDX_DEF = 15;
    localparam int unsigned RB_MAX     = 8;

    typedef struct packed {
        logic              v;
        logic [RB_MAX-1:0] rd;
        logic              we;
        logic              ld;
    } slot_t;

    function automatic int unsigned sel_width(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_prio_enc.sv
// fwd_prio_enc: per-operand forwarding priority encoder (combinational).
//   match_i [DEPTH] - slot k holds a producer of this operand
//   sel_c_o [SELW]  - SEL_RF when nothing matches, else lowest matching k plus 1
module fwd_prio_enc
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned SELW  = 2
) (
    input  logic [DEPTH-1:0] match_i,
    output logic [SELW-1:0]  sel_c_o
);

    // Scan oldest to youngest so the youngest producer overwrites older ones.
    always_comb begin
        sel_c_o = SELW'(SEL_RF);
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            if (match_i[k]) begin
                sel_c_o = SELW'(k + 1);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and forwarding controller for the ID stage.
// Shadows {valid, rd, write-enable, load} of every instruction in the DEPTH
// stages after ID and derives forwarding selects, load-use stall and a
// multi-cycle branch flush. Also keeps a saturating stall-cycle counter.
//   clk, reset            - clock (rising edge), asynchronous active-high reset
//   id_valid/id_rd/id_rf_we/id_load - ID instruction destination info
//   id_src/id_src_used    - NSRC source indices (operand i at [i*RB +: RB]) and use flags
//   branch_taken          - taken branch resolved in EX this cycle
//   stall, flush, fwd_sel - combinational control outputs
//   stall_count           - registered saturating stall counter
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter  int unsigned RB        = 4,
    parameter  int unsigned NSRC      = 3,
    parameter  int unsigned DEPTH     = 3,
    parameter  int unsigned FLUSH_LEN = 1,
    parameter  int unsigned PC_IDX    = PC_IDX_DEF,
    parameter  int unsigned CNTW      = 16,
    localparam int unsigned SELW      = sel_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [RB-1:0]        id_rd,
    input  logic                 id_rf_we,
    input  logic                 id_load,
    input  logic [NSRC*RB-1:0]   id_src,
    input  logic [NSRC-1:0]      id_src_used,
    input  logic                 branch_taken,
    output logic                 stall,
    output logic                 flush,
    output logic [NSRC*SELW-1:0] fwd_sel,
    output logic [CNTW-1:0]      stall_count
);

    localparam int unsigned FCW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

    slot_t            slot_q [DEPTH];
    slot_t            slot_d [DEPTH];
    logic [FCW-1:0]   fcnt_q, fcnt_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [DEPTH-1:0] match [NSRC];
    logic [NSRC-1:0]  src_ok;
    logic             ex_hit;

    // State registers: slot shift register, flush window counter, stall counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                slot_q[k] <= '0;
            end
            fcnt_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                slot_q[k] <= slot_d[k];
            end
            fcnt_q <= fcnt_d;
            cnt_q  <= cnt_d;
        end
    end

    // Operand-vs-slot match matrix; PC and unused operands never match.
    always_comb begin
        for (int i = 0; i < int'(NSRC); i++) begin
            src_ok[i] = id_src_used[i] & (id_src[i*RB +: RB] != RB'(PC_IDX));
            for (int k = 0; k < int'(DEPTH); k++) begin
                match[i][k] = slot_q[k].v & slot_q[k].we & src_ok[i]
                            & (slot_q[k].rd == RB_MAX'(id_src[i*RB +: RB]));
            end
        end
    end

    // Any operand depending on the instruction currently in EX.
    always_comb begin
        ex_hit = 1'b0;
        for (int i = 0; i < int'(NSRC); i++) begin
            ex_hit = ex_hit | match[i][0];
        end
    end

    // Control outputs; flush masks the load-use stall.
    always_comb begin
        flush = branch_taken | (fcnt_q != '0);
        stall = id_valid & ~flush & slot_q[0].ld & ex_hit;
    end

    // Next state: a taken branch (re)starts the window, otherwise count down.
    always_comb begin
        fcnt_d = fcnt_q;
        if (branch_taken) begin
            fcnt_d = FCW'(FLUSH_LEN - 1);
        end else if (fcnt_q != '0) begin
            fcnt_d = fcnt_q - FCW'(1);
        end

        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNTW'(1);
        end

        // Stalled or flushed ID instructions enter EX as a bubble.
        slot_d[0].v  = id_valid & ~stall & ~flush;
        slot_d[0].rd = RB_MAX'(id_rd);
        slot_d[0].we = id_rf_we;
        slot_d[0].ld = id_load;
        for (int k = 1; k < int'(DEPTH); k++) begin
            slot_d[k] = slot_q[k-1];
        end
    end

    assign stall_count = cnt_q;

    for (genvar i = 0; i < int'(NSRC); i++) begin : g_enc
        fwd_prio_enc #(
            .DEPTH (DEPTH),
            .SELW  (SELW)
        ) u_enc (
            .match_i (match[i]),
            .sel_c_o (fwd_sel[i*SELW +: SELW])
        );
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int RB   = 4;
    localparam int NSRC = 3;
    localparam int SELW = 2;
    localparam int CNTW = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 id_valid;
    logic [RB-1:0]        id_rd;
    logic                 id_rf_we;
    logic                 id_load;
    logic [NSRC*RB-1:0]   id_src;
    logic [NSRC-1:0]      id_src_used;
    logic                 branch_taken;
    logic                 stall;
    logic                 flush;
    logic [NSRC*SELW-1:0] fwd_sel;
    logic [CNTW-1:0]      stall_count;

    pipe_hazard_ctrl #(
        .RB        (RB),
        .NSRC      (NSRC),
        .DEPTH     (3),
        .FLUSH_LEN (2),
        .PC_IDX    (15),
        .CNTW      (CNTW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rd        (id_rd),
        .id_rf_we     (id_rf_we),
        .id_load      (id_load),
        .id_src       (id_src),
        .id_src_used  (id_src_used),
        .branch_taken (branch_taken),
        .stall        (stall),
        .flush        (flush),
        .fwd_sel      (fwd_sel),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       v;
        logic [3:0] rd;
        logic       we;
        logic       ld;
        logic [3:0] s0, s1, s2;
        logic [2:0] used;
        logic       br;
        logic       st;
        logic       fl;
        logic [5:0] sel;
        logic [1:0] cnt;
    } vec_t;

    typedef struct {
        string      name;
        logic       st;
        logic       fl;
        logic [5:0] sel;
        logic [1:0] cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(string nm, int v, int rd, int we, int ld,
                                int s0, int s1, int s2, int used, int br,
                                int st, int fl, int f0, int f1, int f2, int cnt);
        vec_t t;
        t.name = nm;
        t.v    = 1'(v);
        t.rd   = 4'(rd);
        t.we   = 1'(we);
        t.ld   = 1'(ld);
        t.s0   = 4'(s0);
        t.s1   = 4'(s1);
        t.s2   = 4'(s2);
        t.used = 3'(used);
        t.br   = 1'(br);
        t.st   = 1'(st);
        t.fl   = 1'(fl);
        t.sel  = {2'(f2), 2'(f1), 2'(f0)};
        t.cnt  = 2'(cnt);
        return t;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        id_valid     = t.v;
        id_rd        = t.rd;
        id_rf_we     = t.we;
        id_load      = t.ld;
        id_src       = {t.s2, t.s1, t.s0};
        id_src_used  = t.used;
        branch_taken = t.br;
    endtask

    // Drive on the falling edge, compare 1 time unit later, before the next rising edge.
    task automatic apply(input vec_t t);
        exp_t e;
        @(negedge clk);
        drive(t);
        e.name = t.name;
        e.st   = t.st;
        e.fl   = t.fl;
        e.sel  = t.sel;
        e.cnt  = t.cnt;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        chk($sformatf("%s.stall", e.name), int'(stall), int'(e.st));
        chk($sformatf("%s.flush", e.name), int'(flush), int'(e.fl));
        chk($sformatf("%s.fwd_sel", e.name), int'(fwd_sel), int'(e.sel));
        chk($sformatf("%s.stall_count", e.name), int'(stall_count), int'(e.cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //             name      v rd we ld s0 s1 s2 us br | st fl f0 f1 f2 cnt
        vecs.push_back(mk("add_r1",  1, 1, 1, 0, 2, 3, 0, 3, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("dist1",   1, 2, 1, 0, 1, 3, 0, 3, 0,  0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("nop_a",   0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("dist23",  1, 0, 0, 0, 1, 2, 0, 3, 0,  0, 0, 3, 2, 0, 0));
        vecs.push_back(mk("dist3x",  1, 0, 0, 0, 2, 1, 0, 3, 0,  0, 0, 3, 0, 0, 0));
        vecs.push_back(mk("dist4",   1, 0, 0, 0, 2, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("mov_r4a", 1, 4, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("mov_r4b", 1, 4, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("young",   1, 0, 0, 0, 4, 4, 4, 7, 0,  0, 0, 1, 1, 1, 0));
        vecs.push_back(mk("usedmsk", 1, 0, 0, 0, 4, 4, 4, 2, 0,  0, 0, 0, 2, 0, 0));
        vecs.push_back(mk("ldr_r5",  1, 5, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lu_stl",  1, 6, 1, 0, 5, 0, 0, 3, 0,  1, 0, 1, 0, 0, 0));
        vecs.push_back(mk("lu_fwd",  1, 6, 1, 0, 5, 0, 0, 3, 0,  0, 0, 2, 0, 0, 1));
        vecs.push_back(mk("nop_b",   0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("ldr_r7",  1, 7, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("nop_c",   0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("ld_mem",  1, 0, 0, 0, 7, 0, 0, 1, 0,  0, 0, 2, 0, 0, 1));
        vecs.push_back(mk("mov_pc",  1, 15, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("rd_pc",   1, 0, 0, 0, 15, 15, 0, 3, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("ldr_pc",  1, 15, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("rd_pc2",  1, 0, 0, 0, 15, 0, 0, 1, 0,  0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("br_add",  1, 8, 1, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 1));
        vecs.push_back(mk("fl_c2",   1, 0, 0, 0, 8, 0, 0, 1, 0,  0, 1, 0, 0, 0, 1));
        vecs.push_back(mk("fl_end",  1, 0, 0, 0, 8, 0, 0, 1, 0,  0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("br2_c1",  0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 1));
        vecs.push_back(mk("br2_c2",  0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 1));
        vecs.push_back(mk("br2_c3",  0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1));
        vecs.push_back(mk("br2_off", 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("ldr_r9",  1, 9, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("fl_ovst", 1, 0, 0, 0, 9, 0, 0, 1, 1,  0, 1, 1, 0, 0, 1));
        vecs.push_back(mk("fl_ov2",  1, 0, 0, 0, 9, 0, 0, 1, 0,  0, 1, 2, 0, 0, 1));
        vecs.push_back(mk("fl_ov3",  1, 0, 0, 0, 9, 0, 0, 1, 0,  0, 0, 3, 0, 0, 1));
        vecs.push_back(mk("ldr_r10", 1, 10, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("sat_s2",  1, 0, 0, 0, 10, 0, 0, 1, 0, 1, 0, 1, 0, 0, 1));
        vecs.push_back(mk("sat_f2",  1, 0, 0, 0, 10, 0, 0, 1, 0, 0, 0, 2, 0, 0, 2));
        vecs.push_back(mk("ldr_r11", 1, 11, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk("sat_s3",  1, 0, 0, 0, 11, 0, 0, 1, 0, 1, 0, 1, 0, 0, 2));
        vecs.push_back(mk("sat_f3",  1, 0, 0, 0, 11, 0, 0, 1, 0, 0, 0, 2, 0, 0, 3));
        vecs.push_back(mk("ldr_r12", 1, 12, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
        vecs.push_back(mk("sat_s4",  1, 0, 0, 0, 12, 0, 0, 1, 0, 1, 0, 1, 0, 0, 3));
        vecs.push_back(mk("sat_f4",  1, 0, 0, 0, 12, 0, 0, 1, 0, 0, 0, 2, 0, 0, 3));
        vecs.push_back(mk("ldr_r13", 1, 13, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
        vecs.push_back(mk("sat_s5",  1, 0, 0, 0, 13, 0, 0, 1, 0, 1, 0, 1, 0, 0, 3));
        vecs.push_back(mk("sat_f5",  1, 0, 0, 0, 13, 0, 0, 1, 0, 0, 0, 2, 0, 0, 3));
        vecs.push_back(mk("ldr_r14", 1, 14, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
        vecs.push_back(mk("rb_br",   1, 0, 0, 0, 14, 0, 0, 1, 1, 0, 1, 1, 0, 0, 3));
        vecs.push_back(mk("rb_fl2",  1, 0, 0, 0, 14, 0, 0, 1, 0, 0, 1, 2, 0, 0, 3));

        // Reset state, with an ID instruction present.
        reset = 1'b1;
        drive(mk("rst", 1, 1, 1, 1, 1, 2, 3, 7, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        #1;
        chk("reset.stall", int'(stall), 0);
        chk("reset.flush", int'(flush), 0);
        chk("reset.fwd_sel", int'(fwd_sel), 0);
        chk("reset.stall_count", int'(stall_count), 0);
        reset = 1'b0;

        foreach (vecs[n]) begin
            apply(vecs[n]);
        end

        // Reset in the middle of a flush window: everything clears immediately.
        #1;
        reset = 1'b1;
        #1;
        chk("rst_fl.flush", int'(flush), 0);
        chk("rst_fl.stall", int'(stall), 0);
        chk("rst_fl.fwd_sel", int'(fwd_sel), 0);
        chk("rst_fl.stall_count", int'(stall_count), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_rel.fwd_sel", int'(fwd_sel), 0);
        chk("rst_rel.flush", int'(flush), 0);

        // Reset in the middle of a load-use stall.
        apply(mk("ldr_r3",  1, 3, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        apply(mk("st_r3",   1, 0, 0, 0, 3, 0, 0, 1, 0,  1, 0, 1, 0, 0, 0));
        #1;
        reset = 1'b1;
        #1;
        chk("rst_st.stall", int'(stall), 0);
        chk("rst_st.fwd_sel", int'(fwd_sel), 0);
        @(negedge clk);
        reset = 1'b0;
        apply(mk("post_rst", 1, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
